mem_copy_master: RTL and testbench

- Bus-master engine that drives the data memory's request interface: address, write_data, mem_read, mem_write, with read_data returned.
- Copies a block of `length` words from `src_addr` to `dst_addr` using word addressing. The memory decodes only address[15:0].
- Sits beside the CPU datapath and is muxed onto the data memory port by the top level while `busy` is high.
- Each word takes two cycles: a read cycle, then a write cycle.

---
 rtl/mem_copy_master.sv | 195 +++++++++++++++++++
 tb/tb_mem_copy_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// Bus-master block copy engine: reads a word from the source and then writes it to the destination, one word at a time.
// Optional fill mode, which writes one constant word to a range of destinations, is built when MEM_COPY_FILL_EN is defined.
module mem_copy_master #(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
`ifdef MEM_COPY_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_value,
`endif
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data,
    output logic             mem_read,
    output logic             mem_write,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_copied
);

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [31:0]      data_buf_r;
    logic [31:0]      cur_src_r;
    logic [31:0]      cur_dst_r;
    logic [LEN_W-1:0] remaining_r;
    logic [LEN_W-1:0] words_copied_r;
    logic             start_fill_s;
    logic             fill_mode_s;
    logic [31:0]      start_buf_s;

    logic [31:0]      mem_address_s;
    logic [31:0]      mem_write_data_s;
    logic             mem_read_s;
    logic             mem_write_s;
    logic             busy_s;
    logic             done_s;

`ifdef MEM_COPY_FILL_EN
    logic             fill_mode_r;

    // Fill-mode flag, latched alongside the other start parameters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_mode_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            fill_mode_r <= fill;
        end else begin
            fill_mode_r <= fill_mode_r;
        end
    end

    assign start_fill_s = fill;
    assign fill_mode_s  = fill_mode_r;
    assign start_buf_s  = fill ? fill_value : data_buf_r;
`else
    assign start_fill_s = 1'b0;
    assign fill_mode_s  = 1'b0;
    assign start_buf_s  = data_buf_r;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; fill mode bypasses RD and repeats WR
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length != {LEN_W{1'b0}}) begin
                        state_next_s = start_fill_s ? WR : RD;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD:   state_next_s = WR;
            WR: begin
                if (remaining_r == LEN_W'(1)) begin
                    state_next_s = DONE;
                end else if (fill_mode_s) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RD;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath registers: start-parameter capture, read buffer, address and count stepping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_buf_r     <= WORD_ZERO;
            cur_src_r      <= WORD_ZERO;
            cur_dst_r      <= WORD_ZERO;
            remaining_r    <= {LEN_W{1'b0}};
            words_copied_r <= {LEN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cur_src_r      <= src_addr;
                        cur_dst_r      <= dst_addr;
                        remaining_r    <= length;
                        words_copied_r <= {LEN_W{1'b0}};
                        data_buf_r     <= start_buf_s;
                    end
                end
                RD: begin
                    data_buf_r <= mem_read_data;
                    cur_src_r  <= cur_src_r + ADDR_STEP;
                end
                WR: begin
                    cur_dst_r      <= cur_dst_r + ADDR_STEP;
                    remaining_r    <= remaining_r - LEN_W'(1);
                    words_copied_r <= words_copied_r + LEN_W'(1);
                end
                default: begin
                    data_buf_r <= data_buf_r;
                end
            endcase
        end
    end

    // Output decode; memory strobes are masked while reset is held so the reset edge never writes
    always_comb begin
        mem_address_s    = WORD_ZERO;
        mem_write_data_s = WORD_ZERO;
        mem_read_s       = 1'b0;
        mem_write_s      = 1'b0;
        busy_s           = 1'b0;
        done_s           = 1'b0;
        case (state_r)
            RD: begin
                mem_read_s    = 1'b1;
                mem_address_s = cur_src_r;
                busy_s        = 1'b1;
            end
            WR: begin
                mem_write_s      = 1'b1;
                mem_address_s    = cur_dst_r;
                mem_write_data_s = data_buf_r;
                busy_s           = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
        if (!rst_n) begin
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
        end else begin
            mem_read_s  = mem_read_s;
            mem_write_s = mem_write_s;
        end
    end

    assign mem_address    = mem_address_s;
    assign mem_write_data = mem_write_data_s;
    assign mem_read       = mem_read_s;
    assign mem_write      = mem_write_s;
    assign busy           = busy_s;
    assign done           = done_s;
    assign words_copied   = words_copied_r;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed self-checking bench for mem_copy_master with a 64K-word memory model driven by the engine's memory port.
// Fill-mode scenarios are included when MEM_COPY_FILL_EN is defined.
module tb_mem_copy_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
`ifdef MEM_COPY_FILL_EN
    logic        fill;
    logic [31:0] fill_value;
`endif
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic [15:0] words_copied;

    logic [31:0] mem [0:65535];
    int          n_checks;
    int          n_fail;
    int          rd_cnt;
    int          wr_cnt;
    int          done_cnt;
    logic [31:0] rd_log [0:7];

    mem_copy_master #(.LEN_W(16), .ADDR_STEP(32'd1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
`ifdef MEM_COPY_FILL_EN
        .fill           (fill),
        .fill_value     (fill_value),
`endif
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .busy           (busy),
        .done           (done),
        .words_copied   (words_copied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is only meaningful while mem_read is high; otherwise return a poison word
    assign mem_read_data = mem_read ? mem[mem_address[15:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[15:0]] <= mem_write_data;
        if (mem_read) begin
            if (rd_cnt < 8) rd_log[rd_cnt] = mem_address;
            rd_cnt = rd_cnt + 1;
        end
        if (mem_write) wr_cnt = wr_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic clear_counters();
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
    endtask

    // Called at #1 after an edge with the DUT idle; returns in cycle 1 after the accept edge
    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                              input logic hold);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        length   = 16'h0;
    endtask

    // Cycle index (from 1) at which done is first seen; 0 when the bound expires
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            if (done) begin
                cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(1);
        n_checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, mem_read, mem_write});
        end
        n_checks++;
        if (mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_address, mem_write_data);
        end
        n_checks++;
        if (words_copied !== 16'd0) begin
            n_fail++; $display("FAIL reset_words got=%0d exp=0", words_copied);
        end
    endtask

    task automatic test_copy_basic();
        int cyc;
        mem[2] = 32'h0000_FFFF;
        mem[3] = 32'h1234_5678;
        clear_counters();
        start_copy(32'h2, 32'h10, 16'd2, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || mem_read !== 1'b1 || mem_address !== 32'h2) begin
            n_fail++; $display("FAIL basic_rd1 got busy=%b rd=%b addr=%h exp 1 1 00000002", busy, mem_read, mem_address);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++; $display("FAIL basic_done_cycle got=%0d exp=5", cyc);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_in_done got=%b exp=0", busy);
        end
        idle_cycles(2);
        n_checks++;
        if (mem[16] !== 32'h0000_FFFF || mem[17] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL basic_data got=%h %h exp=0000ffff 12345678", mem[16], mem[17]);
        end
        n_checks++;
        if (words_copied !== 16'd2) begin
            n_fail++; $display("FAIL basic_words got=%0d exp=2", words_copied);
        end
        n_checks++;
        if (rd_cnt !== 2 || wr_cnt !== 2 || done_cnt !== 1) begin
            n_fail++; $display("FAIL basic_counts got rd=%0d wr=%0d done=%0d exp 2 2 1", rd_cnt, wr_cnt, done_cnt);
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        clear_counters();
        start_copy(32'h5, 32'h30, 16'd0, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 1) begin
            n_fail++; $display("FAIL zero_done_cycle got=%0d exp=1", cyc);
        end
        idle_cycles(2);
        n_checks++;
        if (rd_cnt !== 0 || wr_cnt !== 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL zero_counts got rd=%0d wr=%0d done=%0d exp 0 0 1", rd_cnt, wr_cnt, done_cnt);
        end
        n_checks++;
        if (words_copied !== 16'd0) begin
            n_fail++; $display("FAIL zero_words got=%0d exp=0", words_copied);
        end
    endtask

    task automatic test_reset_mid_copy();
        clear_counters();
        start_copy(32'h0, 32'h20, 16'd4, 1'b0);
        idle_cycles(3);
        n_checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h21) begin
            n_fail++; $display("FAIL rstmid_wr2 got wr=%b addr=%h exp 1 00000021", mem_write, mem_address);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_mask got wr=%b rd=%b exp 0 0", mem_write, mem_read);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0000 || mem_address !== 32'h0 || words_copied !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_idle got ctrl=%b addr=%h words=%0d exp 0000 0 0",
                               {busy, done, mem_read, mem_write}, mem_address, words_copied);
        end
        idle_cycles(10);
        n_checks++;
        if (mem[32] !== 32'hA500_0000) begin
            n_fail++; $display("FAIL rstmid_word1 got=%h exp=a5000000", mem[32]);
        end
        n_checks++;
        if (mem[33] !== 32'hA500_0021 || mem[34] !== 32'hA500_0022 || mem[35] !== 32'hA500_0023) begin
            n_fail++; $display("FAIL rstmid_untouched got=%h %h %h exp=a5000021 a5000022 a5000023",
                               mem[33], mem[34], mem[35]);
        end
        n_checks++;
        if (done_cnt !== 0 || wr_cnt !== 1) begin
            n_fail++; $display("FAIL rstmid_counts got done=%0d wr=%0d exp 0 1", done_cnt, wr_cnt);
        end
    endtask

    task automatic test_start_ignored();
        clear_counters();
        start_copy(32'h50, 32'h60, 16'd3, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            src_addr = 32'h100 + k;
            dst_addr = 32'h200 + k;
            length   = 16'd9;
            @(posedge clk); #1;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL ignore_done_cycle got=%b exp=1", done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(15);
        n_checks++;
        if (wr_cnt !== 3 || done_cnt !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_counts got wr=%0d done=%0d busy=%b exp 3 1 0", wr_cnt, done_cnt, busy);
        end
        n_checks++;
        if (mem[96] !== 32'hA500_0050 || mem[98] !== 32'hA500_0052 || words_copied !== 16'd3) begin
            n_fail++; $display("FAIL ignore_data got=%h %h words=%0d exp a5000050 a5000052 3",
                               mem[96], mem[98], words_copied);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        clear_counters();
        start_copy(32'hFFFF_FFFF, 32'h40, 16'd2, 1'b0);
        wait_done(cyc);
        idle_cycles(2);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++; $display("FAIL wrap_done_cycle got=%0d exp=5", cyc);
        end
        n_checks++;
        if (rd_cnt !== 2 || rd_log[0] !== 32'hFFFF_FFFF || rd_log[1] !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_addr got n=%0d %h %h exp 2 ffffffff 00000000", rd_cnt, rd_log[0], rd_log[1]);
        end
        n_checks++;
        if (mem[64] !== 32'hA500_FFFF || mem[65] !== 32'hA500_0000) begin
            n_fail++; $display("FAIL wrap_data got=%h %h exp=a500ffff a5000000", mem[64], mem[65]);
        end
    endtask

`ifdef MEM_COPY_FILL_EN
    task automatic test_fill();
        int cyc;
        clear_counters();
        fill       = 1'b1;
        fill_value = 32'hFFFF_0000;
        start_copy(32'h0, 32'hB, 16'd3, 1'b0);
        fill       = 1'b0;
        fill_value = 32'h0;
        wait_done(cyc);
        idle_cycles(2);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++; $display("FAIL fill_done_cycle got=%0d exp=4", cyc);
        end
        n_checks++;
        if (mem[11] !== 32'hFFFF_0000 || mem[12] !== 32'hFFFF_0000 || mem[13] !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL fill_data got=%h %h %h exp=ffff0000 x3", mem[11], mem[12], mem[13]);
        end
        n_checks++;
        if (rd_cnt !== 0 || wr_cnt !== 3 || mem[14] !== 32'hA500_000E) begin
            n_fail++; $display("FAIL fill_counts got rd=%0d wr=%0d next=%h exp 0 3 a500000e", rd_cnt, wr_cnt, mem[14]);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        length   = 16'h0;
`ifdef MEM_COPY_FILL_EN
        fill       = 1'b0;
        fill_value = 32'h0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 32'hA500_0000 | i;
        clear_counters();
        test_reset();
        test_copy_basic();
        test_zero_len();
        test_reset_mid_copy();
        test_start_ignored();
        test_wrap();
`ifdef MEM_COPY_FILL_EN
        test_fill();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
